// File: rtl/entity_update_writer_if.sv
// Update stream from game logic into the entity writer: one slot/entity word per valid/ready beat.
interface entity_update_writer_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_slot;
  logic [13:0] upd_entity;
  logic        upd_last;

  modport master (
    output upd_valid,
    output upd_slot,
    output upd_entity,
    output upd_last,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_slot,
    input  upd_entity,
    input  upd_last,
    output upd_ready
  );
endinterface

// File: rtl/entity_update_writer.sv
// Collects per-slot entity updates into a shadow table and commits a closed batch
// to the eight entity outputs at the start of vertical blanking.
module entity_update_writer (
  input  logic                   clk,
  input  logic                   reset,
  entity_update_writer_if.slave  upd,
  input  logic [9:0]             counter_V,
  input  logic [9:0]             counter_H,
  output logic [13:0]            entity_1,
  output logic [13:0]            entity_2,
  output logic [13:0]            entity_3,
  output logic [13:0]            entity_4,
  output logic [13:0]            entity_5,
  output logic [13:0]            entity_6,
  output logic [13:0]            entity_7,
  output logic [13:0]            entity_8,
  output logic                   frame_commit,
  output logic                   err_location
);

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned ENT_W     = 14;
  localparam int unsigned VISIBLE_V = 480;
  localparam int unsigned NUM_TILES = 192;
  localparam logic [ENT_W-1:0] UNUSED_ENTITY = 14'h3C00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ENT_W-1:0] shadow_q [NUM_SLOTS];
  logic [ENT_W-1:0] active_q [NUM_SLOTS];
  logic             ready_q;
  logic             commit_q;
  logic             err_q;

  logic commit_pt;
  logic bad_loc;
  logic xfer;

  assign commit_pt = (counter_V == 10'(VISIBLE_V)) && (counter_H == 10'd0);
  // ID 4'hF clears a slot, so its location field is never range-checked.
  assign bad_loc   = (upd.upd_entity[13:10] != 4'hF) && (upd.upd_entity[7:0] >= 8'(NUM_TILES));
  assign xfer      = upd.upd_valid && ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= UNUSED_ENTITY;
        active_q[i] <= UNUSED_ENTITY;
      end
    end else begin
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (bad_loc) err_q <= 1'b1;
            else         shadow_q[upd.upd_slot] <= upd.upd_entity;
            if (upd.upd_last) begin
              state_q <= PENDING;
              ready_q <= 1'b0;
            end
          end
        end
        PENDING: begin
          // Active table and pulse land together, one cycle after the commit point.
          if (commit_pt) begin
            state_q  <= COMMIT;
            commit_q <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) active_q[i] <= shadow_q[i];
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign upd.upd_ready = ready_q;
  assign frame_commit  = commit_q;
  assign err_location  = err_q;

  assign entity_1 = active_q[0];
  assign entity_2 = active_q[1];
  assign entity_3 = active_q[2];
  assign entity_4 = active_q[3];
  assign entity_5 = active_q[4];
  assign entity_6 = active_q[5];
  assign entity_7 = active_q[6];
  assign entity_8 = active_q[7];

endmodule

// File: doc/entity_update_writer.md
# entity_update_writer

Writer side of the eight-channel entity interface consumed by the frame buffer controller. Game logic streams per-slot entity updates over a valid/ready handshake into a shadow table. A closed batch is committed atomically to the eight `entity_N` outputs at the start of vertical blanking, so a frame never shows a half-updated scene. It sits between game logic and the frame buffer controller, on the same `counter_V`/`counter_H` timebase.

## Interface
- `VISIBLE_V`, 480: first non-visible line; commit line.
- `NUM_TILES`, 192: valid tile locations are 0..NUM_TILES-1 (16×12 grid).
- `UNUSED_ENTITY`, 14'h3C00: ID 4'hF, orientation 0, location 0; marks an unused channel.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `upd_valid`  in  1  update word present.
- `upd_ready`  out  1  writer accepts an update this cycle.
- `upd_slot`  in  3  target channel; 0 maps to entity_1, 7 to entity_8.
- `upd_entity`  in  14  {ID[13:10], orientation[9:8], location[7:0]}.
- `upd_last`  in  1  qualifies the accepted word as the final word of the batch.
- `counter_V`  in  10  current line.
- `counter_H`  in  10  current pixel.
- `entity_1`..`entity_8`  out  14 each  committed entity table; registered.
- `frame_commit`  out  1  one-cycle pulse when the table is updated.
- `err_location`  out  1  one-cycle pulse when a write is dropped for a bad location.

## Operation
- Storage: shadow[0:7] and active[0:7], 14 bits each. `entity_N` = active[N-1].
- Transfer: occurs on a rising edge with `upd_valid && upd_ready`.
  - If the ID is not 4'hF and location ≥ NUM_TILES, the shadow is unchanged and `err_location` pulses.
  - Otherwise shadow[upd_slot] <= upd_entity. ID 4'hF is always accepted regardless of location; it clears the slot.
- Multiple writes to the same slot within a batch: the last one wins.
- Shadow persists across commits, so a batch only needs to carry changed slots.
- FSM:
  - IDLE: `upd_ready`=1. A transfer with `upd_last`=1 moves to PENDING. The word is written first, or dropped if its location is bad; the batch still closes.
  - PENDING: `upd_ready`=0. At commit point (`counter_V`==VISIBLE_V && `counter_H`==0) moves to COMMIT.
  - COMMIT: one cycle. active <= shadow; `frame_commit`=1; next state IDLE.
- Commit point reached in IDLE (no closed batch): no action; active is unchanged even if the shadow holds partial writes.
- Batch closed on the exact commit-point cycle: the FSM enters PENDING on that edge and misses this frame. Commit occurs at the next frame's commit point.
- Reset, including mid-batch or in PENDING/COMMIT:
  - shadow and active all become UNUSED_ENTITY.
  - FSM goes to IDLE.
  - Pending batch is discarded.

## Timing
- Reset values: `entity_1..8`=14'h3C00, `upd_ready`=1, `frame_commit`=0, `err_location`=0.
- `upd_ready` is registered from state. It falls the cycle after the `upd_last` transfer.
- PENDING→COMMIT: on the edge where the commit point is sampled.
  - Active outputs change and `frame_commit` is high in the following cycle: 1-cycle latency from commit point.
  - `upd_ready` rises in the cycle after that.
- `err_location` is high the cycle after the offending transfer.
- Commit is always in vertical blanking. Outputs never change while `counter_V` < VISIBLE_V except by reset.
- Throughput: 1 update/cycle in IDLE. At most one batch per frame.

## Test plan
- Reset check: assert `reset` 2 cycles → all `entity_N`=14'h3C00, `upd_ready`=1, no pulses.
- Single-word batch: slot 2, entity 14'h0914 (ID 2, orient 1, loc 20), `upd_last`=1, at V=100.
  - `upd_ready` drops the next cycle.
  - `entity_3` stays 14'h3C00 until the commit point V=480,H=0.
  - One cycle later `entity_3`=14'h0914, `frame_commit`=1 for exactly one cycle, other slots unchanged, `upd_ready` back to 1 the next cycle.
- Multi-write batch: slot 0 ← 14'h0405, then slot 0 ← 14'h0406 (last) → after commit `entity_1`=14'h0406.
- Bad location: slot 1, ID 3, loc 200, no last → `err_location` pulses, `entity_2` unchanged after a later batch commit. Same word with ID 4'hF is accepted.
- Batch closes on the commit-point cycle:
  - No commit that frame; `entity_N` unchanged through V=524.
  - Commit occurs at the next V=480,H=0.
- Reset in PENDING: batch pending at V=300, assert reset → outputs remain/return 14'h3C00, no `frame_commit` at V=480, `upd_ready`=1.
